// File: rtl/seq_divider_if.sv
// +----------------------------------------------------------------------------+
// | Module   : seq_divider_if                                                  |
// | Brief    : Request/result bundle for the sequential divider.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             div0;
  logic             busy;
  logic             done;

  modport master (
    output start, is_signed, A, B,
    input  HI, LO, div0, busy, done
  );

  modport slave (
    input  start, is_signed, A, B,
    output HI, LO, div0, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
// +----------------------------------------------------------------------------+
// | Module   : seq_divider                                                     |
// | Brief    : Restoring signed/unsigned divider, one quotient bit per cycle.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  localparam int              c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_step;
  logic             w_fix;

  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div0;
  logic             r_busy;
  logic             r_done;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  assign w_a_neg  = bus.is_signed & bus.A[WIDTH-1];
  assign w_b_neg  = bus.is_signed & bus.B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -bus.A : bus.A;
  assign w_b_mag  = w_b_neg ? -bus.B : bus.B;
  assign w_b_zero = (bus.B == '0);

  // Extra top bit makes the trial subtraction's sign the restore decision.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {2'b00, r_dvs};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_b_zero ? S_IDLE : S_DIV;
        end
      end
      S_DIV: begin
        w_step = 1'b1;
        if (r_cnt == c_LAST) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div0  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (w_b_zero) begin
          r_hi   <= bus.A;
          r_lo   <= '1;
          r_div0 <= 1'b1;
          r_done <= 1'b1;
        end else begin
          r_div0  <= 1'b0;
          r_rem   <= '0;
          r_quo   <= w_a_mag;
          r_dvs   <= w_b_mag;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      end
      if (w_step) begin
        r_cnt <= r_cnt + c_ONE;
        if (w_diff[WIDTH+1]) begin
          r_rem <= w_shift[WIDTH:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
        end else begin
          r_rem <= w_diff[WIDTH:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b1};
        end
      end
      if (w_fix) begin
        r_hi   <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        r_lo   <= r_neg_q ? -r_quo : r_quo;
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
  assign bus.div0 = r_div0;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_divider                                                  |
// | Brief    : Directed-vector self-checking bench for seq_divider.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_divider;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  seq_divider_if #(.WIDTH(32)) bus32 ();
  seq_divider_if #(.WIDTH(8))  bus8 ();

  seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Launch from the current (off-edge) time; returns #1 after the done edge.
  // inj >= 0 raises a competing start that many cycles into the operation.
  task automatic op(input string tag, input bit sg, input logic [31:0] a, input logic [31:0] b,
                    input int inj, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                    input bit exp_d0);
    int k;
    int nbusy;
    bus32.start     = 1'b1;
    bus32.is_signed = sg;
    bus32.A         = a;
    bus32.B         = b;
    @(posedge clk);
    #1;
    bus32.start     = 1'b0;
    bus32.is_signed = ~sg;
    bus32.A         = 32'hDEAD_BEEF;
    bus32.B         = 32'h0000_0003;
    k     = 0;
    nbusy = 0;
    while (!bus32.done && k < 200) begin
      if (bus32.busy) nbusy++;
      @(posedge clk);
      #1;
      k++;
      if (k == inj) begin
        bus32.start = 1'b1;
        bus32.A     = 32'd5;
        bus32.B     = 32'd1;
      end else begin
        bus32.start = 1'b0;
      end
    end
    bus32.start = 1'b0;
    check({tag, "_lo"},   bus32.LO, exp_lo);
    check({tag, "_hi"},   bus32.HI, exp_hi);
    check({tag, "_div0"}, bus32.div0, exp_d0);
    // Nonzero divisor: WIDTH DIV edges plus the FIX edge; busy spans DIV and FIX cycles.
    check({tag, "_lat"},  k, exp_d0 ? 0 : 33);
    check({tag, "_busy"}, nbusy, exp_d0 ? 0 : 33);
  endtask

  initial begin
    int  k;
    bit  seen;
    n_chk           = 0;
    n_pass          = 0;
    reset           = 1'b0;
    bus32.start     = 1'b1;
    bus32.is_signed = 1'b0;
    bus32.A         = 32'd100;
    bus32.B         = 32'd7;
    bus8.start      = 1'b0;
    bus8.is_signed  = 1'b0;
    bus8.A          = 8'h00;
    bus8.B          = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_lo",   bus32.LO, 32'h0);
    check("rst_hi",   bus32.HI, 32'h0);
    check("rst_div0", bus32.div0, 1'b0);
    check("rst_busy", bus32.busy, 1'b0);
    check("rst_done", bus32.done, 1'b0);
    bus32.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    op("u100_7",  1'b0, 32'd100,        32'd7,          -1, 32'd14,         32'd2,          1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_lo",   bus32.LO, 32'd14);
    check("hold_hi",   bus32.HI, 32'd2);
    check("hold_done", bus32.done, 1'b0);

    op("s_m7_2",  1'b1, 32'hFFFF_FFF9,  32'd2,          -1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    op("s_7_m2",  1'b1, 32'd7,          32'hFFFF_FFFE,  -1, 32'hFFFF_FFFD,  32'd1,          1'b0);
    op("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1, 32'd14,         32'hFFFF_FFFE,  1'b0);
    op("u_ff_10", 1'b0, 32'hFFFF_FFFF,  32'h10,         -1, 32'h0FFF_FFFF,  32'hF,          1'b0);
    op("s_ff_10", 1'b1, 32'hFFFF_FFFF,  32'h10,         -1, 32'h0,          32'hFFFF_FFFF,  1'b0);
    op("div0",    1'b0, 32'h1234,       32'h0,          -1, 32'hFFFF_FFFF,  32'h1234,       1'b1);
    op("clr_d0",  1'b0, 32'd1000,       32'd10,         -1, 32'd100,        32'd0,          1'b0);
    op("min_m1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  -1, 32'h8000_0000,  32'h0,          1'b0);
    check("b2b_launch", bus32.done, 1'b1);
    op("b2b_9_3", 1'b1, 32'd9,          32'd3,          -1, 32'd3,          32'd0,          1'b0);
    op("ign_start", 1'b0, 32'd100,      32'd7,           5, 32'd14,         32'd2,          1'b0);

    // Abort an operation with reset 10 cycles in.
    bus32.start     = 1'b1;
    bus32.is_signed = 1'b0;
    bus32.A         = 32'd1000;
    bus32.B         = 32'd3;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_lo",   bus32.LO, 32'h0);
    check("abort_hi",   bus32.HI, 32'h0);
    check("abort_busy", bus32.busy, 1'b0);
    check("abort_done", bus32.done, 1'b0);
    bus32.start = 1'b1;
    bus32.B     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_hold_lo",   bus32.LO, 32'h0);
    check("abort_hold_div0", bus32.div0, 1'b0);
    @(negedge clk);
    bus32.start = 1'b0;
    reset       = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus32.done) seen = 1'b1;
    end
    check("abort_nodone", seen, 1'b0);
    op("post_rst", 1'b0, 32'd100, 32'd7, -1, 32'd14, 32'd2, 1'b0);

    // WIDTH=8 instance.
    bus8.start     = 1'b1;
    bus8.is_signed = 1'b0;
    bus8.A         = 8'hF0;
    bus8.B         = 8'h0F;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.A     = 8'h11;
    k = 0;
    while (!bus8.done && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("w8_lo",  bus8.LO, 8'h10);
    check("w8_hi",  bus8.HI, 8'h00);
    check("w8_lat", k, 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
